// File: rtl/serial_seq_tx_if.sv
// ---------------------------------------------------------------------------
// serial_seq_tx_if
// Frame request / serial output bundle for serial_seq_tx.
//   start  : frame request, honoured only while ready=1
//   data   : 8-bit pattern, bit 0 sent first
//   len    : frame length minus one
//   rpt    : number of extra repetitions of the frame
//   ready  : transmitter idle
//   out    : serial bit, 0 whenever valid=0
//   valid  : out carries a frame bit
//   done   : one-cycle pulse after the last bit of the last repetition
//   state  : current FSM state
// master = frame requester, slave = transmitter.
// ---------------------------------------------------------------------------
interface serial_seq_tx_if;
  logic       start;
  logic [7:0] data;
  logic [2:0] len;
  logic [1:0] rpt;
  logic       ready;
  logic       out;
  logic       valid;
  logic       done;
  logic [1:0] state;

  modport master (
    output start, data, len, rpt,
    input  ready, out, valid, done, state
  );

  modport slave (
    input  start, data, len, rpt,
    output ready, out, valid, done, state
  );
endinterface

// File: rtl/serial_seq_tx.sv
// ---------------------------------------------------------------------------
// serial_seq_tx
// Serializes a captured 8-bit pattern LSB-first, one bit per clock, with
// optional repetitions separated by a single idle gap cycle.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : serial_seq_tx_if.slave (start/data/len/rpt in,
//            ready/out/valid/done/state out)
// All outputs come straight from flops.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready=1, waiting for start; captures data/len/rpt on start
// SEND  | valid=1, one frame bit per cycle, LSB first
// GAP   | one idle cycle between repetitions, reloads the pattern
// DONE  | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module serial_seq_tx (
  input  logic           clk,
  input  logic           rst_n,
  serial_seq_tx_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t     state_q;
  logic [7:0] data_q;
  logic [2:0] len_q;
  logic [1:0] rpt_q;
  logic [6:0] sh_q;     // bits still to be sent after the one on out_q
  logic [2:0] bit_q;    // index of the bit currently on out_q
  logic [1:0] rep_q;    // repetition currently being sent
  logic       out_q;
  logic       valid_q;
  logic       done_q;
  logic       ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      len_q   <= '0;
      rpt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            data_q  <= bus.data;
            len_q   <= bus.len;
            rpt_q   <= bus.rpt;
            // First bit goes straight to the output flop so it appears
            // one cycle after acceptance.
            out_q   <= bus.data[0];
            sh_q    <= bus.data[7:1];
            bit_q   <= '0;
            rep_q   <= '0;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            state_q <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (bit_q == len_q) begin
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            if (rep_q != rpt_q) begin
              state_q <= ST_GAP;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else begin
            out_q <= sh_q[0];
            sh_q  <= {1'b0, sh_q[6:1]};
            bit_q <= bit_q + 3'd1;
          end
        end

        ST_GAP: begin
          out_q   <= data_q[0];
          sh_q    <= data_q[7:1];
          bit_q   <= '0;
          rep_q   <= rep_q + 2'd1;
          valid_q <= 1'b1;
          state_q <= ST_SEND;
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.out   = out_q;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: doc/serial_seq_tx.md
# serial_seq_tx

Serial bit-stream transmitter that serializes a captured 8-bit pattern LSB-first, one bit per clock, optionally repeating the frame with a one-cycle gap between repetitions. It is the producing end of the single-bit `in` stream consumed by the lab's Mealy sequence machines and drives their serial input during bring-up and on-board demos. A ready/start handshake accepts a frame. Valid qualifies each transmitted bit, and done pulses once per accepted frame.

## Interface
- No parameters; data width fixed at 8 bits.
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  frame request; accepted only when ready=1
- data  input  8  pattern; bit 0 is transmitted first
- len  input  3  frame length minus one (0 → 1 bit, 7 → 8 bits)
- rpt  input  2  extra repetitions (0 → frame sent once, 3 → four times)
- ready  output  1  block idle, start will be accepted
- out  output  1  serial bit; 0 whenever valid=0
- valid  output  1  out carries a frame bit this cycle
- done  output  1  one-cycle pulse after the final bit of the final repetition
- state  output  2  current FSM state (IDLE=00, SEND=01, GAP=10, DONE=11)

## Operation
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values: state=IDLE, ready=1, out=0, valid=0, done=0. Internal shift register, bit counter and repeat counter all clear to 0.
- **Capture:** on a rising edge with state=IDLE and start=1, the block latches data, len and rpt into internal registers.
  - Changes on data, len or rpt after acceptance have no effect until the next acceptance.
  - start while state≠IDLE is ignored. It is not queued.
- **IDLE:** ready=1, valid=0, out=0. Goes to SEND on accepted start, else stays in IDLE.
- **SEND:** valid=1, out = current LSB of the shift register. The shift register shifts right each cycle, and the 3-bit bit counter increments.
  - After the bit with counter==len, go to GAP if the repeat counter < rpt.
  - Otherwise go to DONE.
- **GAP:** exactly one cycle with valid=0 and out=0.
  - The shift register reloads from the latched data, the bit counter clears, and the 2-bit repeat counter increments.
  - Next state is always SEND.
- **DONE:** exactly one cycle with done=1, valid=0, out=0, ready=0. Next state is always IDLE.
- ready is 1 only in IDLE.
- Counters never wrap during a legal frame. The bit counter reaches at most 7 and the repeat counter at most 3, both compared for equality.
- **Reset mid-operation:** rst_n=0 at any edge forces every reset value at that edge. The frame in progress is abandoned with no done pulse, and the latched values are discarded.
- **Simultaneous events:** rst_n=0 together with start → reset wins and the start is not accepted.

## Timing
- Let cycle 0 be the cycle in which start=1 is sampled with ready=1.
  - Cycles 1..len+1: valid=1, out = data[0]..data[len].
- Repetition r (0-based) occupies cycles r·(len+2)+1 through r·(len+2)+len+1. A GAP cycle follows each repetition except the last.
- done=1 in cycle (rpt+1)·(len+2), and the block is back in IDLE with ready=1 in the following cycle.
- Earliest next acceptance is in the first IDLE cycle. With start held high, consecutive frames are separated by DONE plus one IDLE cycle.
- Latency from acceptance to the first bit: 1 cycle. Throughput during SEND: 1 bit per cycle.

## Test plan
- **Single 8-bit frame:** data=0xA5, len=7, rpt=0, start at cycle 0 → out=1,0,1,0,0,1,0,1 with valid=1 on cycles 1–8; done=1 on cycle 9; ready=1 on cycle 10.
- **Minimum length:** data=0x02, len=0, rpt=0 → single bit out=0, valid=1 on cycle 1; done on cycle 2.
- **Repeats:** data=0x05, len=2, rpt=2 → out 1,0,1 on cycles 1–3, 5–7 and 9–11; valid=0 on cycles 4 and 8; done on cycle 12.
- **Busy-ignore and capture:**
  - Stimulus: data=0xFF, len=3 accepted; data set to 0x00 and start pulsed on cycle 2.
  - Required response: out=1 on cycles 1–4, done on cycle 5, no second frame starts, ready=1 on cycle 6.
- **Reset mid-frame:** data=0xA5, len=7, rpt=1; rst_n=0 on cycle 4 → from cycle 5, state=00, ready=1, valid=0, out=0, and done never pulses. A fresh start then produces a full correct frame.
- **Back-to-back:** start held high, data=0x03, len=1, rpt=0 → frames on cycles 1–2 and 5–6; done on cycles 3 and 7.
